// File: rtl/comp_seq_n_bit_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, result triple, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } comp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } comp_res_t;

  // Bits needed to hold values 0..n-1, never less than one bit so a
  // single-chunk build still has a legal index register.
  function automatic int clog2_safe(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/comp_seq_n_bit_if.sv
// Request/result bundle of the sequential comparator; max_o/min_o exist only with COMP_MINMAX_EN.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while busy is low; there is no queue.
interface comp_seq_n_bit_if #(
  parameter int N = 8
);
  logic         start;
  logic         signed_mode;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         busy;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;
`ifdef COMP_MINMAX_EN
  logic [N-1:0] max_o;
  logic [N-1:0] min_o;

  modport master (output start, signed_mode, X, Y,
                  input  busy, done, gt, eq, lt, max_o, min_o);
  modport slave  (input  start, signed_mode, X, Y,
                  output busy, done, gt, eq, lt, max_o, min_o);
`else
  modport master (output start, signed_mode, X, Y,
                  input  busy, done, gt, eq, lt);
  modport slave  (input  start, signed_mode, X, Y,
                  output busy, done, gt, eq, lt);
`endif
endinterface

// File: rtl/comp_seq_n_bit_chunk.sv
// Combinational unsigned compare of one W-bit chunk into a one-hot gt/eq/lt triple.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module comp_chunk
  import comp_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output comp_res_t    res_o
);

  // Exactly one of the three flags is set for any pair of inputs.
  always_comb begin
    res_o.gt = (a_i >  b_i);
    res_o.eq = (a_i == b_i);
    res_o.lt = (a_i <  b_i);
  end

endmodule

// File: rtl/comp_seq_n_bit.sv
// Multi-cycle MSB-first magnitude compare, CHUNK bits per cycle, early exit; COMP_MINMAX_EN adds max_o/min_o.
// Latency: done pulses m edges after the accepting edge, m = chunks examined (1..N/CHUNK).
// Backpressure: start ignored while busy; a start held in the done cycle is accepted back-to-back.
module comp_seq_n_bit
  import comp_pkg::*;
#(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input logic              clk,
  input logic              rst_n,
  comp_seq_n_bit_if.slave  bus
);

  localparam int NCHUNK = N / CHUNK;
  localparam int IW     = clog2_safe(NCHUNK);
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  if ((N % CHUNK) != 0) begin : g_bad_chunk
    $error("comp_seq_n_bit: N must be a multiple of CHUNK");
  end

  comp_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    y_q, y_d;
  logic            sm_q, sm_d;
  comp_res_t       res_q, res_d;
`ifdef COMP_MINMAX_EN
  logic [N-1:0]    max_q, max_d;
  logic [N-1:0]    min_q, min_d;
`endif

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  comp_res_t        chunk_res;

  // Select the current chunk; flipping the sign bit maps two's complement
  // order onto unsigned order, and only the top chunk carries that bit.
  always_comb begin
    a_chunk = x_q[int'(idx_q) * CHUNK +: CHUNK];
    b_chunk = y_q[int'(idx_q) * CHUNK +: CHUNK];
    if (sm_q && (idx_q == IDX_TOP)) begin
      a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
      b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
    end
  end

  comp_chunk #(.W(CHUNK)) u_chunk (
    .a_i   (a_chunk),
    .b_i   (b_chunk),
    .res_o (chunk_res)
  );

  // Next-state: accept in IDLE/DONE, walk chunks down in CMP, finish on first difference or last chunk.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    sm_d    = sm_q;
    res_d   = res_q;
`ifdef COMP_MINMAX_EN
    max_d   = max_q;
    min_d   = min_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = CMP;
          idx_d   = IDX_TOP;
          x_d     = bus.X;
          y_d     = bus.Y;
          sm_d    = bus.signed_mode;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (!chunk_res.eq || (idx_q == '0)) begin
          state_d = DONE;
          res_d   = chunk_res;
`ifdef COMP_MINMAX_EN
          if (chunk_res.lt) begin
            max_d = y_q;
            min_d = x_q;
          end else begin
            max_d = x_q;
            min_d = y_q;
          end
`endif
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset mid-compare simply aborts with everything cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sm_q    <= 1'b0;
      res_q   <= '0;
`ifdef COMP_MINMAX_EN
      max_q   <= '0;
      min_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sm_q    <= sm_d;
      res_q   <= res_d;
`ifdef COMP_MINMAX_EN
      max_q   <= max_d;
      min_q   <= min_d;
`endif
    end
  end

  assign bus.busy = (state_q == CMP);
  assign bus.done = (state_q == DONE);
  assign bus.gt   = res_q.gt;
  assign bus.eq   = res_q.eq;
  assign bus.lt   = res_q.lt;
`ifdef COMP_MINMAX_EN
  assign bus.max_o = max_q;
  assign bus.min_o = min_q;
`endif

endmodule

// File: tb/tb_comp_seq_n_bit.sv
// Scoreboard bench for comp_seq_n_bit: directed cases plus randomized operands against an arithmetic model.
// Latency: expected done m edges after acceptance, m from the first differing chunk.
// Backpressure: driver only starts when busy is low, which includes the done cycle.
module tb_comp_seq_n_bit;

  localparam int N      = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = N / CHUNK;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comp_seq_n_bit_if #(.N(N)) bus ();

  comp_seq_n_bit #(.N(N), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         gt;
    logic         eq;
    logic         lt;
    int           lat;
    int           stamp;
    logic [N-1:0] mx;
    logic [N-1:0] mn;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer compare in the chosen number system; latency from
  // the highest differing bit position, counted in chunks from the MSB.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic sm);
    exp_t e;
    int xi, yi;
    logic [N-1:0] diff;
    bit found;
    xi = sm ? int'($signed(x)) : int'(x);
    yi = sm ? int'($signed(y)) : int'(y);
    e.gt = (xi > yi);
    e.eq = (xi == yi);
    e.lt = (xi < yi);
    diff = x ^ y;
    e.lat = NCHUNK;
    found = 1'b0;
    for (int b = N - 1; b >= 0; b--) begin
      if (!found && diff[b]) begin
        e.lat = (N - 1 - b) / CHUNK + 1;
        found = 1'b1;
      end
    end
    e.mx = (xi >= yi) ? x : y;
    e.mn = (xi >= yi) ? y : x;
    e.stamp = 0;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse, checks results, latency,
  // busy duration, and that results stay frozen while busy.
  initial begin : monitor
    logic [2:0] held;
    int         busy_cnt;
    exp_t       e;
    held = '0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
        busy_cnt = 0;
      end else begin
        if (bus.busy) begin
          busy_cnt++;
          check("hold_while_busy", 32'({bus.gt, bus.eq, bus.lt}), 32'(held));
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("result_gt_eq_lt", 32'({bus.gt, bus.eq, bus.lt}), 32'({e.gt, e.eq, e.lt}));
            check("latency", 32'(cyc - e.stamp), 32'(e.lat));
            check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
`ifdef COMP_MINMAX_EN
            check("max_o", 32'(bus.max_o), 32'(e.mx));
            check("min_o", 32'(bus.min_o), 32'(e.mn));
`endif
            held = {e.gt, e.eq, e.lt};
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Waits for busy low (idle or done cycle), then presents start for one edge.
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic sm, input bit expect_it);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", guard);
    end
    bus.start       = 1'b1;
    bus.X           = x;
    bus.Y           = y;
    bus.signed_mode = sm;
    @(posedge clk);
    #1;
    check("accept_busy", 32'(bus.busy), 32'd1);
    if (expect_it) begin
      e = model(x, y, sm);
      e.stamp = cyc;
      sb.push_back(e);
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [N-1:0] corner [5];
    logic [N-1:0] rx, ry;
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'hFF;

    bus.start = 1'b0; bus.X = '0; bus.Y = '0; bus.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res",  32'({bus.gt, bus.eq, bus.lt}), 32'd0);
    #1 rst_n = 1'b1;

    issue(8'hA5, 8'h35, 1'b0, 1'b1);
    issue(8'h3C, 8'h3C, 1'b0, 1'b1);
    issue(8'hFF, 8'h01, 1'b1, 1'b1);
    issue(8'hFF, 8'h01, 1'b0, 1'b1);
    issue(8'h80, 8'h7F, 1'b1, 1'b1);

    // A start while busy must be dropped; the next two ops run back-to-back.
    issue(8'h3C, 8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.X = 8'hFF; bus.Y = 8'h00; bus.signed_mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 1'b1);
    issue(8'h56, 8'h56, 1'b1, 1'b1);
    wait_drain();

    // Reset in the second compare cycle aborts without a done.
    issue(8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_res",  32'({bus.gt, bus.eq, bus.lt}), 32'd0);
`ifdef COMP_MINMAX_EN
    check("abort_max", 32'(bus.max_o), 32'd0);
    check("abort_min", 32'(bus.min_o), 32'd0);
`endif
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    issue(8'h01, 8'h02, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        issue(corner[i], corner[j], 1'b0, 1'b1);
        issue(corner[i], corner[j], 1'b1, 1'b1);
      end
    end

    for (int k = 0; k < 2500; k++) begin
      rx = N'($urandom);
      if ($urandom_range(0, 3) == 0) ry = rx ^ N'(1 << $urandom_range(0, N - 1));
      else if ($urandom_range(0, 7) == 0) ry = rx;
      else ry = N'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(rx, ry, 1'($urandom_range(0, 1)), 1'b1);
    end

    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
